branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Optional statistics counters are compiled in with BP_STATS_EN.
module branch_predictor #(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc_F,
    output logic        o_pred_taken_F,
    output logic [31:0] o_pred_target_F,
    input  logic        i_br_E,
    input  logic [31:0] i_pc_E,
    input  logic        i_br_sel,
    input  logic [31:0] i_target_E,
    input  logic        i_pred_taken_E,
    input  logic [31:0] i_pred_target_E,
    output logic        o_mispredict,
    output logic [31:0] o_pc_redirect
`ifdef BP_STATS_EN
    ,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mp_count
`endif
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic            valid   [BTB_ENTRIES];
    logic [TAGW-1:0] tags    [BTB_ENTRIES];
    logic [31:0]     targets [BTB_ENTRIES];
    logic [1:0]      ctrs    [BTB_ENTRIES];

    logic [IDX-1:0]  idx_f;
    logic [IDX-1:0]  idx_e;
    logic [TAGW-1:0] tag_f;
    logic [TAGW-1:0] tag_e;
    logic            hit_f;
    logic            hit_e;
    logic            unused_pc_bits;

    assign idx_f = i_pc_F[IDX+1:2];
    assign tag_f = i_pc_F[31:IDX+2];
    assign idx_e = i_pc_E[IDX+1:2];
    assign tag_e = i_pc_E[31:IDX+2];
    assign unused_pc_bits = ^i_pc_F[1:0];

    // Lookup reads the registered table only, so a same-cycle update is not visible.
    assign hit_f = valid[idx_f] && (tags[idx_f] == tag_f);
    assign hit_e = valid[idx_e] && (tags[idx_e] == tag_e);

    assign o_pred_taken_F  = hit_f & ctrs[idx_f][1];
    assign o_pred_target_F = o_pred_taken_F ? targets[idx_f] : 32'd0;

    assign o_mispredict = i_br_E & ((i_pred_taken_E != i_br_sel) |
                          (i_br_sel & i_pred_taken_E & (i_pred_target_E != i_target_E)));
    assign o_pc_redirect = !o_mispredict ? 32'd0 :
                           (i_br_sel ? i_target_E : i_pc_E + 32'd4);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                tags[i]    <= '0;
                targets[i] <= '0;
                ctrs[i]    <= 2'b01;
            end
        end else if (i_br_E) begin
            if (hit_e) begin
                if (i_br_sel) begin
                    if (ctrs[idx_e] != 2'b11) ctrs[idx_e] <= ctrs[idx_e] + 2'b01;
                    targets[idx_e] <= i_target_E;
                end else if (ctrs[idx_e] != 2'b00) begin
                    ctrs[idx_e] <= ctrs[idx_e] - 2'b01;
                end
            end else if (i_br_sel) begin
                // Allocation replaces whatever aliased entry was there.
                valid[idx_e]   <= 1'b1;
                tags[idx_e]    <= tag_e;
                targets[idx_e] <= i_target_E;
                ctrs[idx_e]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_br_count <= 32'd0;
            o_mp_count <= 32'd0;
        end else begin
            if (i_br_E)       o_br_count <= o_br_count + 32'd1;
            if (o_mispredict) o_mp_count <= o_mp_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a table-level model.
module tb_branch_predictor;

    localparam int N   = 16;
    localparam int IDX = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_pc_F;
    logic        o_pred_taken_F;
    logic [31:0] o_pred_target_F;
    logic        i_br_E;
    logic [31:0] i_pc_E;
    logic        i_br_sel;
    logic [31:0] i_target_E;
    logic        i_pred_taken_E;
    logic [31:0] i_pred_target_E;
    logic        o_mispredict;
    logic [31:0] o_pc_redirect;
`ifdef BP_STATS_EN
    logic [31:0] o_br_count;
    logic [31:0] o_mp_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic        m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int unsigned m_br = 0;
    int unsigned m_mp = 0;

    branch_predictor #(.BTB_ENTRIES(N)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_F(i_pc_F),
        .o_pred_taken_F(o_pred_taken_F), .o_pred_target_F(o_pred_target_F),
        .i_br_E(i_br_E), .i_pc_E(i_pc_E), .i_br_sel(i_br_sel), .i_target_E(i_target_E),
        .i_pred_taken_E(i_pred_taken_E), .i_pred_target_E(i_pred_target_E),
        .o_mispredict(o_mispredict), .o_pc_redirect(o_pc_redirect)
`ifdef BP_STATS_EN
        , .o_br_count(o_br_count), .o_mp_count(o_mp_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == (pc >> (IDX + 2)));
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic m_mispred();
        if (!i_br_E) return 1'b0;
        if (i_pred_taken_E != i_br_sel) return 1'b1;
        return i_br_sel && i_pred_taken_E && (i_pred_target_E != i_target_E);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'd0;
            m_tgt[i]   = 32'd0;
            m_ctr[i]   = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic model_check();
        logic        ep;
        logic        emp;
        logic [31:0] red;
        ep  = m_pred(i_pc_F);
        emp = m_mispred();
        red = !emp ? 32'd0 : (i_br_sel ? i_target_E : i_pc_E + 32'd4);
        check("pred_taken", {31'd0, o_pred_taken_F}, {31'd0, ep});
        check("pred_target", o_pred_target_F, ep ? m_tgt[idx_of(i_pc_F)] : 32'd0);
        check("mispredict", {31'd0, o_mispredict}, {31'd0, emp});
        check("pc_redirect", o_pc_redirect, red);
`ifdef BP_STATS_EN
        check("br_count", o_br_count, m_br);
        check("mp_count", o_mp_count, m_mp);
`endif
    endtask

    task automatic model_update();
        int k;
        if (m_mispred()) m_mp++;
        if (!i_br_E) return;
        m_br++;
        k = idx_of(i_pc_E);
        if (m_hit(i_pc_E)) begin
            if (i_br_sel) begin
                m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
                m_tgt[k] = i_target_E;
            end else begin
                m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
            end
        end else if (i_br_sel) begin
            m_valid[k] = 1'b1;
            m_tag[k]   = i_pc_E >> (IDX + 2);
            m_tgt[k]   = i_target_E;
            m_ctr[k]   = 2;
        end
    endtask

    task automatic drive(input logic [31:0] pcf, input logic br, input logic [31:0] pce,
                         input logic sel, input logic [31:0] tgt, input logic pt,
                         input logic [31:0] ptgt);
        i_pc_F = pcf; i_br_E = br; i_pc_E = pce; i_br_sel = sel;
        i_target_E = tgt; i_pred_taken_E = pt; i_pred_target_E = ptgt;
        #4;
        model_check();
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (i_rst_n) model_update();
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 6) |
               (32'($urandom_range(0, 1)) << 20);
    endfunction

    initial begin
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pt;
        i_rst_n = 1'b0;
        i_pc_F = 32'h100; i_br_E = 1'b0; i_pc_E = 32'd0; i_br_sel = 1'b0;
        i_target_E = 32'd0; i_pred_taken_E = 1'b0; i_pred_target_E = 32'd0;
        model_reset();
        #4;
        model_check();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        drive(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0);
        check("first_mp", {31'd0, o_mispredict}, 32'd1);
        check("first_redirect", o_pc_redirect, 32'h80);
        check("first_lookup_miss", {31'd0, o_pred_taken_F}, 32'd0);
        tick();
        drive(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        check("alloc_taken", {31'd0, o_pred_taken_F}, 32'd1);
        check("alloc_target", o_pred_target_F, 32'h80);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
            tick();
        end
        drive(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        check("nt_redirect", o_pc_redirect, 32'h104);
        tick();
        drive(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        check("weak_taken", {31'd0, o_pred_taken_F}, 32'd1);
        tick();
        drive(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        tick();
        drive(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        check("weak_not_taken", {31'd0, o_pred_taken_F}, 32'd0);
        tick();
        drive(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0);
        tick();
        drive(32'h100, 1, 32'h100, 1, 32'h90, 1, 32'h80);
        check("wrong_target_mp", {31'd0, o_mispredict}, 32'd1);
        check("wrong_target_redirect", o_pc_redirect, 32'h90);
        tick();
        drive(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        check("retarget", o_pred_target_F, 32'h90);
        tick();
        drive(32'h200, 1, 32'h200, 0, 32'h0, 1, 32'h300);
        check("pt_actual_nt", o_pc_redirect, 32'h204);
        tick();
        drive(32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h0);
        tick();
        drive(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        check("evicted_miss", {31'd0, o_pred_taken_F}, 32'd0);
        tick();
        drive(32'h140, 1, 32'h140, 0, 32'h0, 1, 32'h300);
        check("same_cycle_old", {31'd0, o_pred_taken_F}, 32'd1);
        check("same_cycle_tgt", o_pred_target_F, 32'h300);
        tick();
        drive(32'h140, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        check("after_same_cycle", {31'd0, o_pred_taken_F}, 32'd0);
        tick();

        drive(32'h100, 1, 32'h100, 1, 32'h700, 0, 32'h0);
        #1;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        model_check();
        @(posedge i_clk); #1;
        model_check();
        i_br_E = 1'b0;
        #2;
        i_rst_n = 1'b1;
        drive(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        check("post_reset_miss", {31'd0, o_pred_taken_F}, 32'd0);
        tick();
        drive(32'h140, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        tick();

        drive(32'h400, 1, 32'h400, 1, 32'h500, 0, 32'h0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(32'h400, 1, 32'h400, 1, 32'h500, 1, 32'h500);
            tick();
        end
        drive(32'h404, 1, 32'h404, 1, 32'h600, 0, 32'h0);
        tick();
        drive(32'h400, 1, 32'h400, 0, 32'h0, 1, 32'h500);
        tick();
        drive(32'h400, 0, 32'h0, 0, 32'h0, 0, 32'h0);
`ifdef BP_STATS_EN
        check("stats_br10", o_br_count, 32'd10);
        check("stats_mp3", o_mp_count, 32'd3);
`endif
        tick();

        for (int i = 0; i < 400; i++) begin
            pc  = rand_pc();
            tgt = 32'($urandom_range(0, 7)) << 4;
            pt  = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : m_pred(pc);
            drive(rand_pc(), ($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)), tgt, pt,
                  ($urandom_range(0, 3) == 0) ? tgt : m_tgt[idx_of(pc)]);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
